qr_back_substitution: RTL

Solver stage that consumes the Q and R factors of a 4x4 channel matrix and solves H·x = y for x. It forms z = Qᵀ·y, then back-substitutes through upper-triangular R to produce x. The datapath is a single time-multiplexed MAC plus a serial divider. It sits downstream of the QR decomposition stage in the MIMO-OFDM detector, with one transaction per subcarrier.

---
 rtl/qr_back_substitution.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/qr_back_substitution.sv
// Solves H*x = y from Q/R factors: z = Q^T*y through one shared MAC, then
// back-substitution through upper-triangular R with a serial restoring divider.
module qr_back_substitution #(
    parameter int FRAC_BITS = 8,
    parameter int DIV_ITERS = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] q_matrix [0:3][0:3],
    input  logic [31:0] r_matrix [0:3][0:3],
    input  logic [31:0] y_vec [0:3],
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] x_vec [0:3],
    output logic        div_zero
);
    localparam int CNT_W = $clog2(DIV_ITERS + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0, ZMAC = 3'd1, BMAC = 3'd2, DIV = 3'd3, DONE = 3'd4
    } state_t;

    function automatic logic [31:0] sat32(input logic signed [63:0] v);
        if (v > 64'sh0000_0000_7FFF_FFFF)      sat32 = 32'h7FFF_FFFF;
        else if (v < 64'shFFFF_FFFF_8000_0000) sat32 = 32'h8000_0000;
        else                                   sat32 = v[31:0];
    endfunction

    function automatic logic signed [63:0] sext32(input logic [31:0] v);
        sext32 = {{32{v[31]}}, v};
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v);
        abs32 = v[31] ? (~v + 32'd1) : v;
    endfunction

    state_t                  state_r;
    logic [31:0]             q_r [0:3][0:3];
    logic [31:0]             r_r [0:3][0:3];
    logic [31:0]             y_r [0:3];
    logic [31:0]             z_r [0:3];
    logic [31:0]             x_r [0:3];
    logic [1:0]              i_r;
    logic [1:0]              k_r;
    logic [CNT_W-1:0]        cnt_r;
    logic signed [63:0]      acc_r;
    logic [31:0]             rem_r;
    logic [DIV_ITERS-1:0]    dq_r;
    logic [31:0]             den_r;
    logic                    num_neg_r;
    logic                    quot_neg_r;
    logic                    den_zero_r;

    logic signed [31:0]      mul_a_s;
    logic signed [31:0]      mul_b_s;
    logic signed [63:0]      full_s;
    logic signed [63:0]      prod_s;
    logic signed [63:0]      acc_add_s;
    logic signed [63:0]      acc_sub_s;
    logic [31:0]             num_s;
    logic [31:0]             den_raw_s;
    logic [32:0]             rem_sh_s;
    logic                    ge_s;
    logic [32:0]             rem_nx_s;
    logic [DIV_ITERS-1:0]    dq_nx_s;
    logic signed [63:0]      q64_s;
    logic signed [63:0]      qs_s;
    logic [31:0]             x_res_s;

    // Shared MAC operand mux, accumulate paths and one restoring-divide step.
    always_comb begin
        if (state_r == ZMAC) begin
            mul_a_s = q_r[k_r][i_r];
            mul_b_s = y_r[k_r];
        end else begin
            mul_a_s = r_r[i_r][k_r];
            mul_b_s = x_r[k_r];
        end
        full_s    = {{32{mul_a_s[31]}}, mul_a_s} * {{32{mul_b_s[31]}}, mul_b_s};
        prod_s    = full_s >>> FRAC_BITS;
        acc_add_s = ((k_r == 2'd0) ? 64'sd0 : acc_r) + prod_s;
        acc_sub_s = acc_r - prod_s;

        num_s     = sat32(acc_r);
        den_raw_s = r_r[i_r][i_r];

        rem_sh_s  = {rem_r, dq_r[DIV_ITERS-1]};
        ge_s      = (rem_sh_s >= {1'b0, den_r});
        rem_nx_s  = ge_s ? (rem_sh_s - {1'b0, den_r}) : rem_sh_s;
        dq_nx_s   = {dq_r[DIV_ITERS-2:0], ge_s};

        // Magnitude quotient, then sign applied: truncation toward zero.
        q64_s     = {{(64-DIV_ITERS){1'b0}}, dq_nx_s};
        qs_s      = quot_neg_r ? -q64_s : q64_s;
        if (den_zero_r) begin
            x_res_s = num_neg_r ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            x_res_s = sat32(qs_s);
        end
    end

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            div_zero   <= 1'b0;
            i_r        <= 2'd0;
            k_r        <= 2'd0;
            cnt_r      <= '0;
            acc_r      <= 64'sd0;
            rem_r      <= 32'd0;
            dq_r       <= '0;
            den_r      <= 32'd0;
            num_neg_r  <= 1'b0;
            quot_neg_r <= 1'b0;
            den_zero_r <= 1'b0;
            for (int a = 0; a < 4; a++) begin
                y_r[a]   <= 32'd0;
                z_r[a]   <= 32'd0;
                x_r[a]   <= 32'd0;
                x_vec[a] <= 32'd0;
                for (int b = 0; b < 4; b++) begin
                    q_r[a][b] <= 32'd0;
                    r_r[a][b] <= 32'd0;
                end
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        q_r      <= q_matrix;
                        r_r      <= r_matrix;
                        y_r      <= y_vec;
                        for (int a = 0; a < 4; a++) begin
                            x_r[a] <= 32'd0;
                        end
                        div_zero <= 1'b0;
                        i_r      <= 2'd0;
                        k_r      <= 2'd0;
                        in_ready <= 1'b0;
                        state_r  <= ZMAC;
                    end
                end
                ZMAC: begin
                    acc_r <= acc_add_s;
                    k_r   <= k_r + 2'd1;
                    if (k_r == 2'd3) begin
                        z_r[i_r] <= sat32(acc_add_s);
                        if (i_r == 2'd3) begin
                            cnt_r   <= '0;
                            state_r <= DIV;
                        end else begin
                            i_r <= i_r + 2'd1;
                        end
                    end
                end
                BMAC: begin
                    acc_r <= acc_sub_s;
                    k_r   <= k_r + 2'd1;
                    if (k_r == 2'd3) begin
                        cnt_r   <= '0;
                        state_r <= DIV;
                    end
                end
                DIV: begin
                    if (cnt_r == '0) begin
                        num_neg_r  <= num_s[31];
                        quot_neg_r <= num_s[31] ^ den_raw_s[31];
                        den_zero_r <= (den_raw_s == 32'd0);
                        den_r      <= abs32(den_raw_s);
                        dq_r       <= {abs32(num_s), {FRAC_BITS{1'b0}}};
                        rem_r      <= 32'd0;
                        cnt_r      <= cnt_r + 1'b1;
                    end else begin
                        rem_r <= rem_nx_s[31:0];
                        dq_r  <= dq_nx_s;
                        if (cnt_r == CNT_W'(DIV_ITERS)) begin
                            x_r[i_r]   <= x_res_s;
                            x_vec[i_r] <= x_res_s;
                            if (den_zero_r) begin
                                div_zero <= 1'b1;
                            end
                            if (i_r == 2'd0) begin
                                out_valid <= 1'b1;
                                state_r   <= DONE;
                            end else begin
                                // Row i-1 subtracts R[i-1][j]*x[j] for j = i..3.
                                i_r     <= i_r - 2'd1;
                                k_r     <= i_r;
                                acc_r   <= sext32(z_r[i_r - 2'd1]);
                                state_r <= BMAC;
                            end
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
